// File: rtl/apb_gpio_pkg.sv
// Shared definitions for the APB GPIO completer: register offsets, bus FSM states
// and the address-error decode.
package apb_gpio_pkg;

   localparam logic [4:0] REG_DATA_OUT   = 5'h00;
   localparam logic [4:0] REG_DIR        = 5'h04;
   localparam logic [4:0] REG_DATA_IN    = 5'h08;
   localparam logic [4:0] REG_IRQ_EN     = 5'h0C;
   localparam logic [4:0] REG_IRQ_POL    = 5'h10;
   localparam logic [4:0] REG_IRQ_STATUS = 5'h14;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_e;

   // upper_nz: any PADDR bit above [4:0] is set.
   function automatic logic addr_error(input logic upper_nz, input logic [4:0] off,
                                       input logic write);
      return upper_nz || (off[1:0] != 2'b00) || (off >= 5'h18) ||
             (write && (off == REG_DATA_IN));
   endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop pad synchroniser followed by a previous-sample flop; flags rising and
// falling edges of the synchronised value.
module gpio_sync_edge #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   logic [WIDTH-1:0] meta_q, sync_q, prev_q;

   // NOTE: non-blocking assignments make the three stages shift as one pipeline;
   // blocking ones would collapse them into a single flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync = sync_q;
   assign rise = sync_q & ~prev_q;
   assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/apb_gpio_slave.sv
// APB3 completer for a bank of GPIO pins: direction/data registers, synchronised
// inputs, per-pin edge interrupts with W1C status and programmable wait states.
module apb_gpio_slave
   import apb_gpio_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int NUM_GPIO    = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic                PCLK,
   input  logic                PRESET,
   input  logic                PSEL,
   input  logic                PENABLE,
   input  logic                PWRITE,
   input  logic [ADDR_W-1:0]   PADDR,
   input  logic [DATA_W-1:0]   PWDATA,
   output logic [DATA_W-1:0]   PRDATA,
   output logic                PREADY,
   output logic                PSLVERR,
   output logic                IRQ,
   input  logic [NUM_GPIO-1:0] gpio_in,
   output logic [NUM_GPIO-1:0] gpio_out,
   output logic [NUM_GPIO-1:0] gpio_oe
);

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

   apb_state_e          state_q, state_d, cur;
   logic [3:0]          cnt_q, cnt_d;
   logic [NUM_GPIO-1:0] data_out_q, dir_q, irq_en_q, irq_pol_q, irq_status_q;
   logic [NUM_GPIO-1:0] sync_in, rise, fall, edge_hit, w1c_mask, wdata;
   logic [DATA_W-1:0]   prdata_q, rd_mux;
   logic                slverr_q, irq_q, upper_nz, err, ready, enter_ready, commit;
   logic [4:0]          off;
   logic                unused_wdata;

   assign off          = PADDR[4:0];
   assign wdata        = PWDATA[NUM_GPIO-1:0];
   assign unused_wdata = ^PWDATA;

   if (ADDR_W > 5) begin : g_upper
      assign upper_nz = |PADDR[ADDR_W-1:5];
   end else begin : g_no_upper
      assign upper_nz = 1'b0;
   end

   assign err = addr_error(upper_nz, off, PWRITE);

   gpio_sync_edge #(.WIDTH(NUM_GPIO)) u_sync (
      .clk  (PCLK),
      .rst  (PRESET),
      .d    (gpio_in),
      .sync (sync_in),
      .rise (rise),
      .fall (fall)
   );

   // The bus setup cycle is seen while the register still says IDLE, so SETUP is
   // decoded from the inputs; this lets PREADY be registered yet zero-wait.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      cur     = state_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE && PSEL && !PENABLE) cur = SETUP;
      case (cur)
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = WAIT_LOAD;
         end
         ACCESS: begin
            if (!PSEL || cnt_q == 4'd0) state_d = IDLE;
            else                       cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign ready       = (state_q == ACCESS) && (cnt_q == 4'd0);
   assign enter_ready = PSEL && (((cur == SETUP) && (WAIT_LOAD == 4'd0)) ||
                                 ((cur == ACCESS) && (cnt_q == 4'd1)));
   assign commit      = ready && PSEL && PWRITE && !err;

   always_comb begin
      rd_mux = '0;
      case (off)
         REG_DATA_OUT:   rd_mux[NUM_GPIO-1:0] = data_out_q;
         REG_DIR:        rd_mux[NUM_GPIO-1:0] = dir_q;
         REG_DATA_IN:    rd_mux[NUM_GPIO-1:0] = sync_in;
         REG_IRQ_EN:     rd_mux[NUM_GPIO-1:0] = irq_en_q;
         REG_IRQ_POL:    rd_mux[NUM_GPIO-1:0] = irq_pol_q;
         REG_IRQ_STATUS: rd_mux[NUM_GPIO-1:0] = irq_status_q;
         default:        rd_mux = '0;
      endcase
   end

   assign edge_hit = (rise & irq_pol_q) | (fall & ~irq_pol_q);
   assign w1c_mask = (commit && off == REG_IRQ_STATUS) ? wdata : '0;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         prdata_q     <= '0;
         slverr_q     <= 1'b0;
         data_out_q   <= '0;
         dir_q        <= '0;
         irq_en_q     <= '0;
         irq_pol_q    <= '0;
         irq_status_q <= '0;
         irq_q        <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (enter_ready) begin
            slverr_q <= err;
            if (!PWRITE) prdata_q <= err ? '0 : rd_mux;
         end
         if (commit) begin
            case (off)
               REG_DATA_OUT: data_out_q <= wdata;
               REG_DIR:      dir_q      <= wdata;
               REG_IRQ_EN:   irq_en_q   <= wdata;
               REG_IRQ_POL:  irq_pol_q  <= wdata;
               default:      ;
            endcase
         end
         // A set event in the same cycle as a W1C on that bit wins.
         irq_status_q <= (irq_status_q & ~w1c_mask) | (edge_hit & irq_en_q);
         irq_q        <= |(irq_status_q & irq_en_q);
      end
   end

   assign PREADY   = ready;
   assign PSLVERR  = ready & slverr_q;
   assign PRDATA   = prdata_q;
   assign IRQ      = irq_q;
   assign gpio_out = data_out_q;
   assign gpio_oe  = dir_q;

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Directed bench for apb_gpio_slave: three instances (0, 3 and 2 wait states, the
// last with 8 pins) sharing one bus, driven by a vector table plus corner sequences.
module tb_apb_gpio_slave;

   logic        clk = 1'b0;
   logic        preset, penable, pwrite;
   logic [2:0]  sel;
   logic [31:0] paddr, pwdata, gpio_in;
   logic [31:0] prdata [3];
   logic        pready [3];
   logic        pslverr [3];
   logic        irq [3];
   logic [31:0] out0, oe0, out1, oe1;
   logic [7:0]  out2, oe2;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   always #5 clk = ~clk;

   apb_gpio_slave #(.WAIT_STATES(0)) u_dut0 (
      .PCLK(clk), .PRESET(preset), .PSEL(sel[0]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
      .PSLVERR(pslverr[0]), .IRQ(irq[0]), .gpio_in(gpio_in), .gpio_out(out0), .gpio_oe(oe0)
   );

   apb_gpio_slave #(.WAIT_STATES(3)) u_dut3 (
      .PCLK(clk), .PRESET(preset), .PSEL(sel[1]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
      .PSLVERR(pslverr[1]), .IRQ(irq[1]), .gpio_in(gpio_in), .gpio_out(out1), .gpio_oe(oe1)
   );

   apb_gpio_slave #(.NUM_GPIO(8), .WAIT_STATES(2)) u_dut2 (
      .PCLK(clk), .PRESET(preset), .PSEL(sel[2]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]),
      .PSLVERR(pslverr[2]), .IRQ(irq[2]), .gpio_in(gpio_in[7:0]), .gpio_out(out2),
      .gpio_oe(oe2)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // One complete transfer on instance d; waits = PENABLE cycle in which PREADY was seen.
   task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int waits);
      @(posedge clk); #1;
      sel = '0;
      sel[d] = 1'b1;
      penable = 1'b0;
      pwrite = wr;
      paddr = addr;
      pwdata = wdata;
      @(posedge clk); #1;
      penable = 1'b1;
      waits = 1;
      while (!pready[d] && waits < 40) begin
         @(posedge clk); #1;
         waits++;
      end
      rdata = prdata[d];
      err = pslverr[d];
      @(posedge clk); #1;
      sel = '0;
      penable = 1'b0;
   endtask

   task automatic xfer_check(input string name, input int d, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata, input logic exp_err,
                             input int exp_waits);
      logic [31:0] rd;
      logic        e;
      int          w;
      apb_xfer(d, wr, addr, wdata, rd, e, w);
      check({name, "_waits"}, w, exp_waits);
      check({name, "_err"}, e, exp_err);
      if (!wr) check({name, "_rdata"}, rd, exp_rdata);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 32'h00, 32'hA5,   32'h0,  1'b0};
      vecs[1]  = '{1'b1, 32'h04, 32'hFF,   32'h0,  1'b0};
      vecs[2]  = '{1'b0, 32'h00, 32'h0,    32'hA5, 1'b0};
      vecs[3]  = '{1'b0, 32'h04, 32'h0,    32'hFF, 1'b0};
      vecs[4]  = '{1'b1, 32'h08, 32'h1234, 32'h0,  1'b1};
      vecs[5]  = '{1'b1, 32'h1C, 32'h1,    32'h0,  1'b1};
      vecs[6]  = '{1'b0, 32'h02, 32'h0,    32'h0,  1'b1};
      vecs[7]  = '{1'b1, 32'h100, 32'h5A,  32'h0,  1'b1};
      vecs[8]  = '{1'b1, 32'h06, 32'h5A,   32'h0,  1'b1};
      vecs[9]  = '{1'b0, 32'h00, 32'h0,    32'hA5, 1'b0};
      vecs[10] = '{1'b0, 32'h18, 32'h0,    32'h0,  1'b1};
      vecs[11] = '{1'b1, 32'h10, 32'h1,    32'h0,  1'b0};
      vecs[12] = '{1'b1, 32'h0C, 32'h1,    32'h0,  1'b0};
      vecs[13] = '{1'b0, 32'h10, 32'h0,    32'h1,  1'b0};
      vecs[14] = '{1'b0, 32'h0C, 32'h0,    32'h1,  1'b0};
      vecs[15] = '{1'b0, 32'h08, 32'h0,    32'h0,  1'b0};
      vecs[16] = '{1'b0, 32'h14, 32'h0,    32'h0,  1'b0};

      preset = 1'b1;
      sel = '0;
      penable = 1'b0;
      pwrite = 1'b0;
      paddr = '0;
      pwdata = '0;
      gpio_in = 32'h3C;
      repeat (3) @(posedge clk);
      #1 preset = 1'b0;

      check("rst_prdata", prdata[0], 32'h0);
      check("rst_pready", pready[0], 1'b0);
      check("rst_pslverr", pslverr[0], 1'b0);
      check("rst_irq", irq[0], 1'b0);
      check("rst_gpio_out", out0, 32'h0);
      check("rst_gpio_oe", oe0, 32'h0);

      // Three wait states: PREADY in the fourth PENABLE cycle, DATA_IN = pads.
      repeat (3) @(posedge clk);
      xfer_check("ws3_data_in", 1, 1'b0, 32'h08, 32'h0, 32'h3C, 1'b0, 4);

      gpio_in = 32'h0;
      repeat (4) @(posedge clk);
      for (int i = 0; i < 17; i++) begin
         xfer_check($sformatf("vec%0d", i), 0, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rdata, vecs[i].err, 1);
      end
      check("gpio_out_a5", out0, 32'hA5);
      check("gpio_oe_ff", oe0, 32'hFF);

      // Rising edge on pin 0 with IRQ_EN=1, IRQ_POL=1.
      gpio_in[0] = 1'b1;
      repeat (5) @(posedge clk);
      #1 check("irq_set", irq[0], 1'b1);
      xfer_check("status_set", 0, 1'b0, 32'h14, 32'h0, 32'h1, 1'b0, 1);
      xfer_check("w1c", 0, 1'b1, 32'h14, 32'h1, 32'h0, 1'b0, 1);
      @(posedge clk); #1;
      check("irq_cleared", irq[0], 1'b0);
      xfer_check("status_cleared", 0, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, 1);
      gpio_in[0] = 1'b0;
      repeat (5) @(posedge clk);
      xfer_check("no_fall_set", 0, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, 1);

      // Rising edge flagged in the very cycle a W1C to the same bit commits.
      @(posedge clk); #1;
      gpio_in[0] = 1'b1;
      @(posedge clk); #1;
      sel = 3'b001;
      penable = 1'b0;
      pwrite = 1'b1;
      paddr = 32'h14;
      pwdata = 32'h1;
      @(posedge clk); #1;
      penable = 1'b1;
      check("set_w1c_ready", pready[0], 1'b1);
      @(posedge clk); #1;
      sel = '0;
      penable = 1'b0;
      xfer_check("set_wins", 0, 1'b0, 32'h14, 32'h0, 32'h1, 1'b0, 1);
      check("set_wins_irq", irq[0], 1'b1);

      // 8-pin instance: upper write bits ignored, then an aborted waited write.
      xfer_check("n8_write", 2, 1'b1, 32'h00, 32'hFFFF_FF11, 32'h0, 1'b0, 3);
      check("n8_gpio_out", out2, 8'h11);
      xfer_check("n8_read", 2, 1'b0, 32'h00, 32'h0, 32'h11, 1'b0, 3);
      @(posedge clk); #1;
      sel = 3'b100;
      penable = 1'b0;
      pwrite = 1'b1;
      paddr = 32'h00;
      pwdata = 32'h77;
      @(posedge clk); #1;
      penable = 1'b1;
      check("abort_wait1", pready[2], 1'b0);
      @(posedge clk); #1;
      check("abort_wait2", pready[2], 1'b0);
      sel = '0;
      penable = 1'b0;
      @(posedge clk); #1;
      check("abort_no_ready", pready[2], 1'b0);
      repeat (3) @(posedge clk);
      #1 check("abort_gpio_out", out2, 8'h11);
      xfer_check("abort_then_read", 2, 1'b0, 32'h00, 32'h0, 32'h11, 1'b0, 3);

      // Reset asserted in the ready cycle of a waited write to DIR.
      xfer_check("dir_pre", 2, 1'b1, 32'h04, 32'h0F, 32'h0, 1'b0, 3);
      check("dir_pre_oe", oe2, 8'h0F);
      check("irq_before_reset", irq[0], 1'b1);
      @(posedge clk); #1;
      sel = 3'b100;
      penable = 1'b0;
      pwrite = 1'b1;
      paddr = 32'h04;
      pwdata = 32'hF0;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_mid_ready", pready[2], 1'b1);
      preset = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_oe", oe2, 8'h00);
      check("rst_mid_pready", pready[2], 1'b0);
      check("rst_mid_irq", irq[0], 1'b0);
      preset = 1'b0;
      sel = '0;
      penable = 1'b0;
      xfer_check("post_rst_write", 2, 1'b1, 32'h04, 32'h33, 32'h0, 1'b0, 3);
      check("post_rst_oe", oe2, 8'h33);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
